// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store engine in front of a word-indexed data memory.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   reqValid / reqReady   request handshake (ready only in IDLE)
//   reqWrite, reqSize,    request fields: store/load, 00 byte / 01 half / 10 word / 11 illegal,
//   reqSigned, reqAddr,   sign-extend on loads, byte address, right-justified store data
//   reqWData
//   respValid, respData,  one-cycle completion pulse with load result and error flag
//   respError
//   address, writeData,   memory port; address is the latched word index, readData is sampled
//   memRead, memWrite,    on the last memRead cycle
//   readData
//
// Sub-word stores are read-modify-write: the old word is read, the addressed lane replaced,
// and the merged word written back.

module load_store_unit #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqSigned,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWData,
  output logic        respValid,
  output logic [31:0] respData,
  output logic        respError,
  output logic [31:0] address,
  output logic [31:0] writeData,
  output logic        memRead,
  output logic        memWrite,
  input  logic [31:0] readData
);

  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;
  localparam logic [1:0] SzWord = 2'b10;

  // Counter counts down to zero, so MEM_LAT cycles means reloading with MEM_LAT-1.
  localparam logic [3:0] CntReload = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {StIdle, StRdWait, StWrite, StResp} state_e;

  state_e      state;
  logic [3:0]  cntQ;
  logic        writeQ;
  logic        signedQ;
  logic [1:0]  sizeQ;
  logic [31:0] addrQ;
  logic [31:0] wdataQ;

  logic        reqErr;
  logic [7:0]  byteLane;
  logic [15:0] halfLane;
  logic [31:0] loadData;
  logic [31:0] mergeData;

  assign reqReady = (state == StIdle);
  assign address  = {2'b00, addrQ[31:2]};

  // Alignment / legality of the request currently on the inputs.
  always_comb begin
    reqErr = 1'b0;
    case (reqSize)
      SzByte:  reqErr = 1'b0;
      SzHalf:  reqErr = reqAddr[0];
      SzWord:  reqErr = |reqAddr[1:0];
      default: reqErr = 1'b1;
    endcase
  end

  // Little-endian lane extraction and lane merge against the latched request.
  always_comb begin
    byteLane  = readData[{addrQ[1:0], 3'b000} +: 8];
    halfLane  = readData[{addrQ[1], 4'b0000} +: 16];
    loadData  = readData;
    mergeData = readData;
    case (sizeQ)
      SzByte: begin
        loadData = {{24{signedQ & byteLane[7]}}, byteLane};
        mergeData[{addrQ[1:0], 3'b000} +: 8] = wdataQ[7:0];
      end
      SzHalf: begin
        loadData = {{16{signedQ & halfLane[15]}}, halfLane};
        mergeData[{addrQ[1], 4'b0000} +: 16] = wdataQ[15:0];
      end
      default: begin
        loadData  = readData;
        mergeData = wdataQ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      cntQ      <= 4'd0;
      writeQ    <= 1'b0;
      signedQ   <= 1'b0;
      sizeQ     <= 2'b00;
      addrQ     <= 32'd0;
      wdataQ    <= 32'd0;
      respValid <= 1'b0;
      respError <= 1'b0;
      respData  <= 32'd0;
      memRead   <= 1'b0;
      memWrite  <= 1'b0;
      writeData <= 32'd0;
    end else begin
      unique case (state)
        StIdle: begin
          if (reqValid) begin
            writeQ  <= reqWrite;
            signedQ <= reqSigned;
            sizeQ   <= reqSize;
            addrQ   <= reqAddr;
            wdataQ  <= reqWData;
            if (reqErr) begin
              state     <= StResp;
              respValid <= 1'b1;
              respError <= 1'b1;
              respData  <= 32'd0;
            end else if (reqWrite && (reqSize == SzWord)) begin
              state     <= StWrite;
              memWrite  <= 1'b1;
              writeData <= reqWData;
            end else begin
              // Loads and sub-word stores both start by reading the addressed word.
              state   <= StRdWait;
              memRead <= 1'b1;
              cntQ    <= CntReload;
            end
          end
        end
        StRdWait: begin
          if (cntQ == 4'd0) begin
            memRead <= 1'b0;
            if (writeQ) begin
              state     <= StWrite;
              memWrite  <= 1'b1;
              writeData <= mergeData;
            end else begin
              state     <= StResp;
              respValid <= 1'b1;
              respError <= 1'b0;
              respData  <= loadData;
            end
          end else begin
            cntQ <= cntQ - 4'd1;
          end
        end
        StWrite: begin
          memWrite  <= 1'b0;
          writeData <= 32'd0;
          state     <= StResp;
          respValid <= 1'b1;
          respError <= 1'b0;
          respData  <= 32'd0;
        end
        StResp: begin
          respValid <= 1'b0;
          respError <= 1'b0;
          respData  <= 32'd0;
          state     <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a transaction-level model turns each accepted
// request into the list of per-cycle outputs the unit must show, and a compare process
// checks every cycle against that list (or against idle outputs when it is empty).

module tb_load_store_unit;

  localparam int unsigned Lat = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  // Main instance (MEM_LAT = 3)
  logic        reqValid, reqReady, reqWrite, reqSigned;
  logic [1:0]  reqSize;
  logic [31:0] reqAddr, reqWData;
  logic        respValid, respError, memRead, memWrite;
  logic [31:0] respData, address, writeData, readData;

  // Second instance (MEM_LAT = 1), word load only
  logic        bValid, bReady, bRespValid, bRespError, bMemRead, bMemWrite;
  logic [31:0] bRespData, bAddress, bWriteData, bReadData;

  load_store_unit #(.MEM_LAT(Lat)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite), .reqSize(reqSize),
    .reqSigned(reqSigned), .reqAddr(reqAddr), .reqWData(reqWData),
    .respValid(respValid), .respData(respData), .respError(respError),
    .address(address), .writeData(writeData), .memRead(memRead), .memWrite(memWrite),
    .readData(readData)
  );

  load_store_unit #(.MEM_LAT(1)) dutB (
    .clk(clk), .rst_n(rst_n),
    .reqValid(bValid), .reqReady(bReady), .reqWrite(1'b0), .reqSize(2'b10),
    .reqSigned(1'b0), .reqAddr(32'h0), .reqWData(32'h0),
    .respValid(bRespValid), .respData(bRespData), .respError(bRespError),
    .address(bAddress), .writeData(bWriteData), .memRead(bMemRead), .memWrite(bMemWrite),
    .readData(bReadData)
  );

  always #5 clk = ~clk;

  // Memory behind the main instance; backdoor writes go through the same process.
  logic [31:0] mem [16];
  logic        bdEn = 1'b0;
  logic [3:0]  bdIdx = 4'd0;
  logic [31:0] bdData = 32'd0;
  assign readData  = mem[address[3:0]];
  assign bReadData = (bAddress == 32'd0) ? 32'h12345678 : 32'hDEADBEEF;

  always @(posedge clk) begin
    if (bdEn) mem[bdIdx] <= bdData;
    else if (memWrite) mem[address[3:0]] <= writeData;
  end

  // ---------------- model ----------------
  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic        rv;
    logic        re;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] addr;
  } exp_t;

  typedef struct {
    logic        w;
    logic [1:0]  s;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
  } req_t;

  exp_t        expQ[$];
  logic [31:0] refMem [16];
  logic [31:0] lastAddr = 32'd0;
  bit          chkEn = 1'b1;
  int          nCmp = 0;
  int          nFail = 0;

  function automatic exp_t mk(input logic rd, input logic wr, input logic [31:0] wdata,
                              input logic rv, input logic re, input logic [31:0] rdata,
                              input logic ready, input logic [31:0] addr);
    exp_t e;
    e.rd = rd; e.wr = wr; e.wdata = wdata; e.rv = rv; e.re = re;
    e.rdata = rdata; e.ready = ready; e.addr = addr;
    return e;
  endfunction

  function automatic bit isErr(input logic [1:0] s, input logic [31:0] a);
    return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [31:0] a,
                                          input logic [1:0] s, input logic sg);
    logic [31:0] v;
    if (s == 2'b00) begin
      v = (word >> (8 * int'(a[1:0]))) & 32'hFF;
      if (sg && v[7]) v = v | 32'hFFFFFF00;
    end else if (s == 2'b01) begin
      v = (word >> (16 * int'(a[1]))) & 32'hFFFF;
      if (sg && v[15]) v = v | 32'hFFFF0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                        input logic [1:0] s, input logic [31:0] wd);
    int          sh;
    logic [31:0] mask;
    sh   = (s == 2'b00) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
    mask = ((s == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  task automatic push_req(input req_t r);
    logic [31:0] aw;
    logic [31:0] m;
    int          idx;
    aw  = {2'b00, r.a[31:2]};
    idx = int'(r.a[5:2]);
    if (isErr(r.s, r.a)) begin
      expQ.push_back(mk(0, 0, 0, 1, 1, 0, 0, aw));
    end else if (r.w && r.s == 2'b10) begin
      expQ.push_back(mk(0, 1, r.wd, 0, 0, 0, 0, aw));
      refMem[idx] = r.wd;
      expQ.push_back(mk(0, 0, 0, 1, 0, 0, 0, aw));
    end else begin
      repeat (Lat) expQ.push_back(mk(1, 0, 0, 0, 0, 0, 0, aw));
      if (r.w) begin
        m = merge(refMem[idx], r.a, r.s, r.wd);
        refMem[idx] = m;
        expQ.push_back(mk(0, 1, m, 0, 0, 0, 0, aw));
        expQ.push_back(mk(0, 0, 0, 1, 0, 0, 0, aw));
      end else begin
        expQ.push_back(mk(0, 0, 0, 1, 0, extract(refMem[idx], r.a, r.s, r.sg), 0, aw));
      end
    end
    lastAddr = aw;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : cmp
    exp_t e;
    if (chkEn) begin
      if (expQ.size() > 0) e = expQ.pop_front();
      else e = mk(0, 0, 0, 0, 0, 0, 1, lastAddr);
      chk("reqReady", 32'(reqReady), 32'(e.ready));
      chk("memRead", 32'(memRead), 32'(e.rd));
      chk("memWrite", 32'(memWrite), 32'(e.wr));
      chk("writeData", writeData, e.wdata);
      chk("respValid", 32'(respValid), 32'(e.rv));
      chk("respError", 32'(respError), 32'(e.re));
      chk("respData", respData, e.rdata);
      chk("address", address, e.addr);
    end
  end

  // Event capture for the literal checks.
  logic [31:0] lastResp = 32'd0, lastWData = 32'd0, lastWAddr = 32'd0;
  logic        lastErr = 1'b0;
  int          rdCycles = 0, wrPulses = 0, respCnt = 0;
  always @(negedge clk) begin
    if (respValid) begin
      lastResp <= respData;
      lastErr  <= respError;
      respCnt  <= respCnt + 1;
    end
    if (memRead) rdCycles <= rdCycles + 1;
    if (memWrite) begin
      wrPulses  <= wrPulses + 1;
      lastWData <= writeData;
      lastWAddr <= address;
    end
  end

  // ---------------- stimulus ----------------
  task automatic poke(input int idx, input logic [31:0] d);
    bdIdx = 4'(idx); bdData = d; bdEn = 1'b1;
    @(posedge clk); #1;
    bdEn = 1'b0;
    refMem[idx] = d;
  endtask

  task automatic drive(input req_t r);
    reqWrite = r.w; reqSize = r.s; reqSigned = r.sg; reqAddr = r.a; reqWData = r.wd;
    reqValid = 1'b1;
  endtask

  // Garbage on the request inputs while an operation is in flight.
  task automatic scramble();
    reqValid = 1'b0; reqWrite = 1'($urandom); reqSize = 2'($urandom);
    reqSigned = 1'($urandom); reqAddr = $urandom; reqWData = $urandom;
  endtask

  function automatic req_t mkReq(input logic w, input logic [1:0] s, input logic sg,
                                 input logic [31:0] a, input logic [31:0] wd);
    req_t r;
    r.w = w; r.s = s; r.sg = sg; r.a = a; r.wd = wd;
    return r;
  endfunction

  function automatic req_t rndReq();
    return mkReq(1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 63)),
                 $urandom);
  endfunction

  task automatic wait_drain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    chk("drain_timeout", 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  task automatic one_req(input req_t r);
    @(posedge clk); #2;
    drive(r);
    @(posedge clk); #1;
    push_req(r);
    scramble();
    wait_drain();
  endtask

  // Two requests with reqValid held: the second is accepted after exactly one IDLE cycle.
  task automatic pair(input req_t x, input req_t y);
    int base, lenB, n;
    @(posedge clk); #2;
    drive(x);
    @(posedge clk); #1;
    push_req(x);
    expQ.push_back(mk(0, 0, 0, 0, 0, 0, 1, {2'b00, x.a[31:2]}));
    base = expQ.size();
    push_req(y);
    lenB = expQ.size() - base;
    drive(y);
    n = 0;
    while (expQ.size() > lenB && n < 60) begin
      @(posedge clk);
      n++;
    end
    #2;
    scramble();
    wait_drain();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int r0, w0, c0;
    logic [31:0] saved0;
    reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00; reqSigned = 1'b0;
    reqAddr = 32'd0; reqWData = 32'd0; bValid = 1'b0;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 16; i++) poke(i, $urandom);
    chk("rst_reqReady", 32'(reqReady), 32'd1);
    chk("rst_address", address, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Word load on the MEM_LAT=1 instance
    chk("B_ready", 32'(bReady), 32'd1);
    @(posedge clk); #2;
    bValid = 1'b1;
    @(posedge clk); #1;
    bValid = 1'b0;
    @(negedge clk);
    chk("B_memRead_c1", 32'(bMemRead), 32'd1);
    chk("B_address_c1", bAddress, 32'd0);
    chk("B_respValid_c1", 32'(bRespValid), 32'd0);
    @(negedge clk);
    chk("B_memRead_c2", 32'(bMemRead), 32'd0);
    chk("B_respValid_c2", 32'(bRespValid), 32'd1);
    chk("B_respData_c2", bRespData, 32'h12345678);
    chk("B_respError_c2", 32'(bRespError), 32'd0);

    // Signed / unsigned byte load
    poke(1, 32'h0000_80FF);
    one_req(mkReq(0, 2'b00, 1, 32'h5, 32'h0));
    chk("lb_signed", lastResp, 32'hFFFFFF80);
    one_req(mkReq(0, 2'b00, 0, 32'h5, 32'h0));
    chk("lb_unsigned", lastResp, 32'h00000080);

    // Half store read-modify-write
    poke(1, 32'hAABBCCDD);
    saved0 = mem[0];
    w0 = wrPulses;
    one_req(mkReq(1, 2'b01, 0, 32'h6, 32'h0000_1234));
    chk("sh_pulses", 32'(wrPulses - w0), 32'd1);
    chk("sh_wdata", lastWData, 32'h1234CCDD);
    chk("sh_waddr", lastWAddr, 32'd1);
    chk("sh_mem1", mem[1], 32'h1234CCDD);
    chk("sh_mem0", mem[0], saved0);

    // Misaligned word load
    r0 = rdCycles; w0 = wrPulses;
    one_req(mkReq(0, 2'b10, 0, 32'h2, 32'h0));
    chk("mis_rd", 32'(rdCycles - r0), 32'd0);
    chk("mis_wr", 32'(wrPulses - w0), 32'd0);
    chk("mis_err", 32'(lastErr), 32'd1);
    chk("mis_data", lastResp, 32'd0);

    // memRead length for MEM_LAT=3
    r0 = rdCycles;
    one_req(mkReq(0, 2'b10, 0, 32'h8, 32'h0));
    chk("lat3_rd", 32'(rdCycles - r0), 32'd3);
    pair(mkReq(0, 2'b10, 0, 32'h8, 32'h0), mkReq(0, 2'b01, 1, 32'h12, 32'h0));

    // Reset during WRITE of a word store aborts it
    w0 = wrPulses; c0 = respCnt;
    @(posedge clk); #2;
    drive(mkReq(1, 2'b10, 0, 32'hC, 32'hCAFEF00D));
    @(posedge clk); #1;
    chkEn = 1'b0;
    scramble();
    chk("abort_inwrite", 32'(memWrite), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_memWrite", 32'(memWrite), 32'd0);
    chk("abort_ready", 32'(reqReady), 32'd1);
    chk("abort_address", address, 32'd0);
    chk("abort_wdata", writeData, 32'd0);
    chk("abort_respValid", 32'(respValid), 32'd0);
    expQ.delete();
    lastAddr = 32'd0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    chk("abort_no_write", 32'(wrPulses - w0), 32'd0);
    chk("abort_no_resp", 32'(respCnt - c0), 32'd0);
    chk("abort_mem3", mem[3], refMem[3]);
    // Accepted on the first edge after reset release
    drive(mkReq(0, 2'b10, 0, 32'hC, 32'h0));
    chkEn = 1'b1;
    @(posedge clk); #1;
    push_req(mkReq(0, 2'b10, 0, 32'hC, 32'h0));
    scramble();
    wait_drain();

    // Randomised traffic
    for (int i = 0; i < 200; i++) begin
      if (i % 8 == 7) pair(rndReq(), rndReq());
      else one_req(rndReq());
    end
    for (int i = 0; i < 16; i++) chk("final_mem", mem[i], refMem[i]);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_LAT, default 1: number of cycles memRead is held before readData is sampled, legal range 1..15.
REQ-002 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-003 Port rst_n  input  1: asynchronous, active-low reset.
REQ-004 Port reqValid  input  1: request present.
REQ-005 Port reqReady  output  1: unit can accept a request this cycle.
REQ-006 Port reqWrite  input  1: 1 = store, 0 = load.
REQ-007 Port reqSize  input  2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-008 Port reqSigned  input  1: loads only; 1 = sign-extend, 0 = zero-extend.
REQ-009 Port reqAddr  input  32: byte address.
REQ-010 Port reqWData  input  32: store data, right-justified.
REQ-011 Port respValid  output  1: one-cycle completion pulse.
REQ-012 Port respData  output  32: load result, valid with respValid, else 0.
REQ-013 Port respError  output  1: misaligned or illegal request, valid with respValid.
REQ-014 Ports address  output  32, writeData  output  32, memRead  output  1, memWrite  output  1, readData  input  32: word-indexed data-memory port.

Function
REQ-015 The unit SHALL implement the states IDLE, RD_WAIT, WRITE and RESP.
REQ-016 reqReady SHALL be 1 only in IDLE; a request is accepted on a rising edge where reqValid and reqReady are both 1.
REQ-017 On acceptance the unit SHALL latch all req* fields; later changes on the req* inputs SHALL NOT affect the operation in flight.
REQ-018 Misaligned or illegal requests SHALL go directly to RESP with respError=1 and respData=0, with no memory access.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
- Illegal: size 11.
REQ-019 address SHALL equal {2'b00, latched addr[31:2]} in every state, and 0 after reset until the first acceptance.
REQ-020 Load: IDLE -> RD_WAIT, with memRead=1 for exactly MEM_LAT cycles.
- readData is sampled on the last of those cycles.
- The selected lane is extended per reqSigned.
- The state then moves to RESP.
REQ-021 Lane select SHALL be little-endian: byte lane = addr[1:0], half lane = addr[1].
REQ-022 Word store: IDLE -> WRITE -> RESP; memWrite=1 and writeData=latched wdata for exactly one cycle in WRITE.
REQ-023 Sub-word store: IDLE -> RD_WAIT (read old word) -> WRITE -> RESP.
- writeData is the old word with only the addressed byte/half lane replaced by the low bits of wdata.
REQ-024 memRead and memWrite SHALL NOT both be 1 in any cycle; writeData SHALL be 0 outside WRITE.
REQ-025 RESP SHALL last one cycle (respValid=1), then return to IDLE; there is no response back-pressure.
REQ-026 Latency, counted in cycles from the acceptance edge to the respValid cycle inclusive:
- error: 1
- word store: 2
- load: MEM_LAT+1
- sub-word store: MEM_LAT+2
REQ-027 A new request MAY be accepted on the edge that ends RESP only via IDLE, so back-to-back operations have one IDLE cycle between them.
REQ-028 The RD_WAIT cycle counter SHALL be 4 bits wide and SHALL reload on each entry to RD_WAIT.

Reset
REQ-029 While rst_n=0 the unit SHALL immediately (asynchronously) force IDLE.
- Outputs: reqReady=1, respValid=0, respError=0, respData=0, memRead=0, memWrite=0, writeData=0, address=0.
- The counter and all latched fields SHALL clear.
REQ-030 A reset asserted mid-operation SHALL abort it: no memWrite pulse and no respValid for that request.
REQ-031 After rst_n deasserts, the unit SHALL accept a request on the first following rising edge.

Verification
REQ-032 Word load, MEM_LAT=1: memory[0]=0x12345678, load word addr 0x0 -> memRead one cycle at address 0; respValid with respData=0x12345678 two cycles after accept.
REQ-033 Signed byte load: memory[1]=0x0000_80FF, load byte signed addr 0x5 -> respData=0xFFFFFF80; unsigned -> 0x00000080.
REQ-034 Half store: memory[1]=0xAABBCCDD, store half 0x1234 at addr 0x6 -> single memWrite with address 1 and writeData=0x1234CCDD; memory[0] unchanged.
REQ-035 Misaligned word load addr 0x2 -> memRead and memWrite stay 0; next-cycle respValid=1, respError=1, respData=0.
REQ-036 Word store with rst_n pulsed low during WRITE -> memWrite falls in the same cycle, no respValid, and reqReady=1 immediately.
REQ-037 MEM_LAT=3 load -> memRead high exactly 3 cycles; respValid on cycle 4 after accept; reqValid held high -> next acceptance only after one IDLE cycle.
